// File: rtl/exec_sequencer.sv
// exec_sequencer: top-level instruction sequencer for the OSECPU core.
// Fetches instruction words over a req/ack handshake, presents them on instr0
// for exactly one EXEC cycle, and owns the PC and control flow (JMP, CND skip, HALT).
// A fetch that waits FETCH_TIMEOUT cycles without ack halts with fault set.
// Optional feature macro: EXEC_STEP_EN. When defined, the sequencer parks in PAUSE
// after each non-halting EXEC and adds a step input. A step pulse resumes fetching.
module exec_sequencer #(
  parameter int PC_W          = 16,
  parameter int START_PC      = 0,
  parameter int FETCH_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            cond_in,
  output logic [31:0]     instr0,
  output logic [3:0]      current_state,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            fault
`ifdef EXEC_STEP_EN
  ,
  input  logic            step
`endif
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FETCH = 4'd1,
    S_WAIT  = 4'd2,
    S_EXEC  = 4'd3,
    S_HALT  = 4'd5,
    S_PAUSE = 4'd6
  } state_t;

  localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);
  // Last counter value tolerated in WAIT; an unacked cycle at this count faults.
  localparam logic [7:0]      TO_LAST    = 8'(FETCH_TIMEOUT - 1);
  localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);

  state_t          r_state, w_state_next;
  logic [PC_W-1:0] r_pc, w_pc_next;
  logic [31:0]     r_instr, w_instr_next;
  logic [7:0]      r_cnt, w_cnt_next;
  logic            r_req, w_req_next;
  logic            r_halted, w_halted_next;
  logic            r_fault, w_fault_next;
  logic            r_skip, w_skip_next;

  // State register; reset drops straight to IDLE, abandoning any open fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and register-update decode for every sequencer state.
  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_instr_next  = r_instr;
    w_cnt_next    = r_cnt;
    w_req_next    = r_req;
    w_halted_next = r_halted;
    w_fault_next  = r_fault;
    w_skip_next   = r_skip;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_FETCH;
          w_pc_next    = START_ADDR;
        end
      end
      S_FETCH: begin
        w_req_next   = 1'b1;
        w_cnt_next   = 8'd0;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack) begin
          w_req_next = 1'b0;
          if (r_skip) begin
            // Word shadowed by a failed CND: drop it and fetch the next one.
            w_skip_next  = 1'b0;
            w_pc_next    = r_pc + PC_ONE;
            w_state_next = S_FETCH;
          end else begin
            w_instr_next = imem_rdata;
            w_state_next = S_EXEC;
          end
        end else if (r_cnt == TO_LAST) begin
          w_req_next    = 1'b0;
          w_fault_next  = 1'b1;
          w_halted_next = 1'b1;
          w_state_next  = S_HALT;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_EXEC: begin
`ifdef EXEC_STEP_EN
        w_state_next = S_PAUSE;
`else
        w_state_next = S_FETCH;
`endif
        case (r_instr[31:24])
          8'hFF: begin
            w_state_next  = S_HALT;
            w_halted_next = 1'b1;
          end
          8'h03: w_pc_next = PC_W'(r_instr[15:0]);
          8'h04: begin
            w_pc_next = r_pc + PC_ONE;
            if (!cond_in) w_skip_next = 1'b1;
          end
          default: w_pc_next = r_pc + PC_ONE;
        endcase
      end
      S_HALT: begin
        if (start) begin
          w_state_next  = S_FETCH;
          w_pc_next     = START_ADDR;
          w_halted_next = 1'b0;
          w_fault_next  = 1'b0;
          w_skip_next   = 1'b0;
        end
      end
`ifdef EXEC_STEP_EN
      S_PAUSE: begin
        if (step) w_state_next = S_FETCH;
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // Architectural registers: PC, latched instruction, handshake and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= START_ADDR;
      r_instr  <= 32'd0;
      r_cnt    <= 8'd0;
      r_req    <= 1'b0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
      r_skip   <= 1'b0;
    end else begin
      r_pc     <= w_pc_next;
      r_instr  <= w_instr_next;
      r_cnt    <= w_cnt_next;
      r_req    <= w_req_next;
      r_halted <= w_halted_next;
      r_fault  <= w_fault_next;
      r_skip   <= w_skip_next;
    end
  end

  assign current_state = r_state;
  assign pc            = r_pc;
  assign imem_addr     = r_pc;
  assign imem_req      = r_req;
  assign instr0        = r_instr;
  assign halted        = r_halted;
  assign fault         = r_fault;

endmodule
